pipe_sum_serializer: RTL and testbench

//  Downstream consumer of the 4-chunk pipelined 128-bit adder. Tracks issued adds through the adder's

---
 rtl/pipe_sum_serializer.sv | 158 +++++++++++++++
 tb/tb_pipe_sum_serializer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_sum_serializer.sv
// Tracks adds through a fixed-latency adder, queues {cout,sum} results and streams each as four H-bit words.
// Optional PIPE_SUM_MSB_FIRST_EN: send the most-significant chunk first.
module pipe_sum_serializer #(
    parameter int H     = 32,
    parameter int LAT   = 5,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [4*H-1:0] sum,
    input  logic           cout,
    output logic [H-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_last,
    output logic           out_carry,
    output logic           overflow_err
);

    localparam int W  = 4 * H + 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(LAT + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [LAT-1:0]  vdl_q, vdl_d;
    logic [IW-1:0]   inflight_q, inflight_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [W-1:0]    hold_q, hold_d;
    logic [1:0]      idx_q, idx_d;
    logic            ovf_q, ovf_d;
    logic [W-1:0]    mem_q [DEPTH];

    logic            emerge;
    logic            fifo_nonempty;
    logic            pop;
    logic            push;
    logic [1:0]      sel;

    assign emerge        = vdl_q[LAT-1];
    assign fifo_nonempty = (count_q != '0);
    assign in_ready      = (32'(count_q) + 32'(inflight_q)) < 32'(DEPTH);

    always_comb begin
        vdl_d      = vdl_q << 1;
        vdl_d[0]   = in_valid;
        inflight_d = inflight_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        hold_d     = hold_q;
        idx_d      = idx_q;
        ovf_d      = ovf_q;
        state_d    = state_q;

        case ({in_valid, emerge})
            2'b10:   inflight_d = inflight_q + IW'(1);
            2'b01:   inflight_d = inflight_q - IW'(1);
            default: inflight_d = inflight_q;
        endcase

        // A full FIFO still accepts a capture when the head leaves on the same edge.
        pop  = fifo_nonempty && ((state_q == S_IDLE) || (out_ready && (idx_q == 2'd3)));
        push = emerge && ((count_q != CW'(DEPTH)) || pop);
        if (emerge && !push) begin
            ovf_d = 1'b1;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    hold_d  = mem_q[rd_ptr_q];
                    idx_d   = 2'd0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (out_ready) begin
                    if (idx_q != 2'd3) begin
                        idx_d = idx_q + 2'd1;
                    end else if (pop) begin
                        hold_d = mem_q[rd_ptr_q];
                        idx_d  = 2'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef PIPE_SUM_MSB_FIRST_EN
    assign sel = ~idx_q;
`else
    assign sel = idx_q;
`endif

    always_comb begin
        out_valid    = (state_q == S_SEND);
        out_data     = out_valid ? hold_q[32'(sel)*H +: H] : '0;
        out_last     = out_valid && (idx_q == 2'd3);
        out_carry    = out_last && hold_q[W-1];
        overflow_err = ovf_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            vdl_q      <= '0;
            inflight_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            hold_q     <= '0;
            idx_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            vdl_q      <= vdl_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            hold_q     <= hold_d;
            idx_q      <= idx_d;
            ovf_q      <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cout, sum};
        end
    end

endmodule

// File: tb/tb_pipe_sum_serializer.sv
// Self-checking bench: emulates the fixed-latency adder and scores every accepted word against a result queue.
module tb_pipe_sum_serializer;

    localparam int H     = 32;
    localparam int LAT   = 5;
    localparam int DEPTH = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [4*H-1:0] sum = '0;
    logic           cout = 1'b0;
    logic [H-1:0]   out_data;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic           out_last;
    logic           out_carry;
    logic           overflow_err;

    pipe_sum_serializer #(.H(H), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .sum          (sum),
        .cout         (cout),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .out_carry    (out_carry),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    int             checks = 0;
    int             errors = 0;
    int             cyc = 0;
    logic [128:0]   exp_q [$];
    int             widx = 0;
    logic [4*H-1:0] a_sum = '0;
    logic           a_cout = 1'b0;
    logic           skip_exp = 1'b0;
    logic           pv [LAT];
    logic [128:0]   pdat [LAT];
    logic           prev_stall = 1'b0;
    logic [H-1:0]   pd;
    logic           pl, pc;
    int             hs_count, hs_first, hs_last;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [H-1:0] word_of(input logic [128:0] d, input int w);
`ifdef PIPE_SUM_MSB_FIRST_EN
        return d[(3-w)*H +: H];
`else
        return d[w*H +: H];
`endif
    endfunction

    task automatic tick();
        logic         iv;
        logic [128:0] d;
        #1;
        if (prev_stall)
            chk("stall_hold", {out_valid, out_last, out_carry, out_data}, {1'b1, pl, pc, pd});
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", out_valid, 1'b0);
            end else begin
                d = exp_q[0];
                chk("word_data", out_data, word_of(d, widx));
                chk("word_last", out_last, widx == 3);
                chk("word_carry", out_carry, (widx == 3) ? d[128] : 1'b0);
                hs_count++;
                if (hs_count == 1) hs_first = cyc;
                hs_last = cyc;
                if (widx == 3) begin
                    widx = 0;
                    void'(exp_q.pop_front());
                end else begin
                    widx++;
                end
            end
        end
        prev_stall = out_valid && !out_ready;
        pd = out_data;
        pl = out_last;
        pc = out_carry;
        iv = in_valid;
        d  = {a_cout, a_sum};
        if (iv && !skip_exp) exp_q.push_back(d);
        @(posedge clk);
        #1;
        cyc++;
        for (int i = LAT - 1; i > 0; i--) begin
            pv[i]   = pv[i-1];
            pdat[i] = pdat[i-1];
        end
        pv[0]   = iv;
        pdat[0] = d;
        if (pv[LAT-1]) {cout, sum} = pdat[LAT-1];
        else {cout, sum} = {$urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic rand_operand();
        a_sum  = {$urandom, $urandom, $urandom, $urandom};
        a_cout = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
        chk("drain_empty", exp_q.size(), 0);
        repeat (8) tick();
    endtask

    initial begin
        int t;
        int issued;
        int valid_seen;
        for (int i = 0; i < LAT; i++) begin
            pv[i]   = 1'b0;
            pdat[i] = '0;
        end

        // Reset state
        #2;
        chk("reset_outputs", {out_valid, out_data, out_last, out_carry, overflow_err}, '0);
        chk("reset_in_ready", in_ready, 1'b1);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Single add: latency, order, last/carry, no bubbles
        a_sum = 128'h00000004_00000003_00000002_00000001;
        a_cout = 1'b0;
        out_ready = 1'b1;
        hs_count = 0;
        t = cyc;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick();
        chk("t1_done", exp_q.size(), 0);
        chk("t1_first_cycle", hs_first, t + LAT + 2);
        chk("t1_last_cycle", hs_last, t + LAT + 5);
        chk("t1_word_count", hs_count, 4);
        repeat (4) tick();

        // Zero sum with carry out
        a_sum = '0;
        a_cout = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        drain();

        // Backpressure: out_ready pattern 1,0,0,1
        for (int k = 0; k < 3; k++) begin
            rand_operand();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            tick();
        end
        chk("t3_done", exp_q.size(), 0);
        drain();

        // Credit: issue only while in_ready, out_ready held low
        out_ready = 1'b0;
        issued = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 4) chk("t4_ready_low_after_4", in_ready, 1'b0);
            rand_operand();
            in_valid = in_ready;
            if (in_ready) issued++;
            tick();
        end
        in_valid = 1'b0;
        repeat (6) tick();
        // one result sits in the serializer, so DEPTH+1 fit without loss
        chk("t4_issued", issued, DEPTH + 1);
        chk("t4_no_overflow", overflow_err, 1'b0);
        drain();

        // Randomized traffic respecting credit
        for (int i = 0; i < 400; i++) begin
            rand_operand();
            in_valid  = in_ready && ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();
        chk("rand_no_overflow", overflow_err, 1'b0);

        // Overrun: 6 issues ignoring in_ready, out_ready low
        out_ready = 1'b0;
        t = cyc;
        for (int k = 0; k < 6; k++) begin
            rand_operand();
            skip_exp = (k == 5);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        skip_exp = 1'b0;
        for (int i = 0; i < 20 && cyc < t + LAT + 5; i++) tick();
        chk("t5_ovf_before", overflow_err, 1'b0);
        tick();
        chk("t5_ovf_set", overflow_err, 1'b1);
        repeat (5) tick();
        chk("t5_ovf_sticky", overflow_err, 1'b1);
        drain();
        chk("t5_ovf_after_drain", overflow_err, 1'b1);

        // Reset during word 2 of a result with 2 queued
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rand_operand();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        chk("t6_valid_seen", out_valid, 1'b1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t6_word2", out_data, word_of(exp_q[0], 1));
        reset = 1'b1;
        #1;
        chk("t6_reset_outputs", {out_valid, out_data, out_last, out_carry, overflow_err}, '0);
        chk("t6_reset_in_ready", in_ready, 1'b1);
        exp_q.delete();
        widx = 0;
        prev_stall = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        valid_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) valid_seen++;
            tick();
        end
        chk("t6_no_stale", valid_seen, 0);
        a_sum = 128'h00000004_00000003_00000002_00000001;
        a_cout = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
